out_port_alloc: RTL and testbench
=================================

OUT_PORT_ALLOC -- requirements
Module: out_port_alloc

Interface
REQ-001 The block SHALL use one clock, clk; reset rst SHALL be asynchronous and active-low.
REQ-002 Parameter TO_W, default 12, SHALL set the watchdog counter width.
REQ-003 Parameter TO_MAX, default 12'd1024, SHALL set the number of stalled HOLD cycles before forced release (legal range 1..2^TO_W-1).
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  asynchronous active-low reset.
REQ-006 req  in  5  per-input request; bit 0=L, 1=N, 2=E, 3=W, 4=S.
REQ-007 flit_valid  in  5  per-input flit present, same bit order.
REQ-008 flit_id  in  15  per-input flit type; port i at [3i+2:3i].
REQ-009 out_ready  in  1  downstream accepts a flit this cycle.
REQ-010 grant  out  5  one-hot registered grant; all-zero when idle.
REQ-011 sel  out  3  encoded granted index 0..4; 3'b111 when idle.
REQ-012 fwd  out  1  combinational: grant active & flit_valid[sel] & out_ready.
REQ-013 busy  out  1  high in HOLD.
REQ-014 timeout  out  1  one-cycle pulse on watchdog release.

Function
REQ-015 Flit codes SHALL be HEAD=3'b001, BODY=3'b010, TAIL=3'b100; other codes are treated as BODY.
REQ-016 FSM SHALL have two states, IDLE and HOLD.
REQ-017 In IDLE, input i SHALL be eligible iff req[i] & flit_valid[i] & flit_id[i]==HEAD.
REQ-018 In IDLE, the winner SHALL be the first eligible index scanning ptr+1, ptr+2, ... modulo 5; grant/sel SHALL update at the next edge (1-cycle latency) and state SHALL go to HOLD.
REQ-019 In IDLE with no eligible input, state, grant, sel and ptr SHALL be unchanged.
REQ-020 In HOLD, grant and sel SHALL be held constant regardless of other requests.
REQ-021 In HOLD, fwd with flit_id[sel]==TAIL SHALL release: next cycle IDLE, grant=0, sel=3'b111, ptr<=sel.
REQ-022 In HOLD, req[sel]=0 SHALL release as in REQ-021 with no timeout pulse (abort).
REQ-023 Watchdog counter SHALL clear on entry to HOLD and on every fwd, else increment, saturating at 2^TO_W-1.
REQ-024 When counter==TO_MAX-1 and fwd=0 in HOLD, the block SHALL release as in REQ-021 and assert timeout for exactly the following cycle.
REQ-025 Simultaneous TAIL-fwd and watchdog limit SHALL count as normal release (no timeout pulse).
REQ-026 After any release, grant SHALL stay zero for at least one cycle before the next grant.

Reset
REQ-027 On rst low: state=IDLE, grant=5'b0, sel=3'b111, busy=0, timeout=0, counter=0, ptr=4 (L highest priority first).
REQ-028 Reset asserted mid-packet SHALL drop the grant immediately without a timeout pulse.

Configuration
REQ-029 With ALLOC_STATS_EN defined, the block SHALL add outputs pkt_cnt (16 b, increments per TAIL release, wraps) and to_cnt (8 b, increments per timeout, saturates at 255), both zero on reset.
REQ-030 Without ALLOC_STATS_EN, those ports and counters SHALL be absent and behaviour otherwise identical.

Structure
REQ-031 Shared package noc_pkg SHALL hold NPORTS=5, port indices L..S, flit codes HEAD/BODY/TAIL and SEL_NONE=3'b111.
REQ-032 Round-robin selection SHALL be a combinational sub-module rr_pick (inputs eligible[5], ptr[3]; outputs valid, idx[3]).

Verification
REQ-033 Reset, then req=5'b00001 with HEAD on L -> grant=5'b00001, sel=0 one cycle later; BODY, TAIL fwd -> grant=0 after TAIL edge.
REQ-034 All five requesting HEAD continuously, each packet 2 flits -> grant order L,N,E,W,S,L with one idle cycle between.
REQ-035 TO_MAX=4, grant E, out_ready=0 held -> release after 4 HOLD cycles, timeout pulses once, ptr=2, next winner W if eligible.
REQ-036 Grant N, drop req[1] mid-packet -> release next cycle, timeout=0, ptr=1.
REQ-037 rst low during HOLD on S -> grant=0, sel=3'b111 immediately; after reset L wins first.
REQ-038 With ALLOC_STATS_EN, 3 packets plus 1 timeout -> pkt_cnt=3, to_cnt=1.

Source files
------------

// File: rtl/noc_pkg.sv
// noc_pkg -- shared router constants for the output-port allocator.
//   NPORTS      : number of router input ports (L, N, E, W, S)
//   P_L..P_S    : port indices, also the bit order of every per-port vector
//   HEAD/BODY/TAIL : flit type codes; any other code behaves as BODY
//   SEL_NONE    : encoded select value when no input owns the output
package noc_pkg;

  localparam int NPORTS = 5;

  localparam int P_L = 0;
  localparam int P_N = 1;
  localparam int P_E = 2;
  localparam int P_W = 3;
  localparam int P_S = 4;

  localparam logic [2:0] HEAD     = 3'b001;
  localparam logic [2:0] BODY     = 3'b010;
  localparam logic [2:0] TAIL     = 3'b100;
  localparam logic [2:0] SEL_NONE = 3'b111;

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} alloc_state_e;

  function automatic logic [NPORTS-1:0] port_onehot(input logic [2:0] idx);
    port_onehot = {{(NPORTS-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick -- combinational round-robin picker.
//   eligible [NPORTS] : ports allowed to win this cycle
//   ptr      [3]      : last winner; scanning starts at ptr+1 (mod NPORTS)
//   valid             : some port is eligible
//   idx      [3]      : winning port index, SEL_NONE when !valid
module rr_pick
  import noc_pkg::*;
(
  input  logic [NPORTS-1:0] eligible,
  input  logic [2:0]        ptr,
  output logic              valid,
  output logic [2:0]        idx
);

  int j;

  // Scan from the farthest offset to the nearest so the last hit, i.e. the
  // one closest after ptr, is what remains in idx.
  always_comb begin
    valid = 1'b0;
    idx   = SEL_NONE;
    j     = 0;
    for (int k = NPORTS; k >= 1; k--) begin
      j = (int'(ptr) + k) % NPORTS;
      if (eligible[j]) begin
        valid = 1'b1;
        idx   = 3'(j);
      end
    end
  end

endmodule

// File: rtl/out_port_alloc.sv
// out_port_alloc -- wormhole output-port allocator with watchdog release.
// An input whose HEAD flit is presented wins the output in round-robin
// order and keeps it until its TAIL is forwarded, it drops its request, or
// the watchdog sees TO_MAX consecutive cycles without forward progress.
//   clk, rst          : clock, asynchronous active-low reset
//   req[5]            : per-input request (bit0=L,1=N,2=E,3=W,4=S)
//   flit_valid[5]     : per-input flit present
//   flit_id[15]       : per-input flit type, port i at [3i+2:3i]
//   out_ready         : downstream accepts a flit this cycle
//   grant[5], sel[3]  : registered one-hot grant / encoded owner (7 = none)
//   fwd               : owner's flit moves downstream this cycle
//   busy              : output is held by a packet
//   timeout           : one-cycle pulse after a watchdog release
// Optional ALLOC_STATS_EN adds pkt_cnt (TAIL releases, wraps) and
// to_cnt (watchdog releases, saturates at 255).
module out_port_alloc
  import noc_pkg::*;
#(
  parameter int              TO_W   = 12,
  parameter logic [TO_W-1:0] TO_MAX = 12'd1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NPORTS-1:0]   req,
  input  logic [NPORTS-1:0]   flit_valid,
  input  logic [3*NPORTS-1:0] flit_id,
  input  logic                out_ready,
  output logic [NPORTS-1:0]   grant,
  output logic [2:0]          sel,
  output logic                fwd,
  output logic                busy,
  output logic                timeout
`ifdef ALLOC_STATS_EN
  ,
  output logic [15:0]         pkt_cnt,
  output logic [7:0]          to_cnt
`endif
);

  localparam logic [TO_W-1:0] TO_LAST = TO_MAX - 1'b1;
  localparam logic [TO_W-1:0] CNT_SAT = '1;

  alloc_state_e               state_q, state_d;
  logic [NPORTS-1:0]          grant_d;
  logic [2:0]                 sel_d;
  logic [2:0]                 ptr_q, ptr_d;
  logic [TO_W-1:0]            cnt_q, cnt_d;
  logic                       to_d;

  logic [NPORTS-1:0][2:0]     id_v;
  logic [NPORTS-1:0]          eligible;
  logic                       pick_v;
  logic [2:0]                 pick_idx;
  logic [2:0]                 cur_id;
  logic                       cur_req;
  logic                       tail_rel;

  assign id_v = flit_id;

  always_comb begin
    for (int i = 0; i < NPORTS; i++)
      eligible[i] = req[i] & flit_valid[i] & (id_v[i] == HEAD);
  end

  rr_pick u_pick (
    .eligible (eligible),
    .ptr      (ptr_q),
    .valid    (pick_v),
    .idx      (pick_idx)
  );

  // Owner's flit type and request, muxed through the one-hot grant so the
  // idle value of sel never indexes past the port vectors.
  always_comb begin
    cur_id = 3'b000;
    for (int i = 0; i < NPORTS; i++)
      if (grant[i]) cur_id = cur_id | id_v[i];
  end

  assign cur_req  = |(req & grant);
  assign busy     = (state_q == HOLD);
  assign fwd      = (|(grant & flit_valid)) & out_ready;
  assign tail_rel = busy & fwd & (cur_id == TAIL);

  always_comb begin
    state_d = state_q;
    grant_d = grant;
    sel_d   = sel;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    to_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_v) begin
          state_d = HOLD;
          grant_d = port_onehot(pick_idx);
          sel_d   = pick_idx;
          cnt_d   = '0;
        end
      end
      HOLD: begin
        // TAIL and abort win over the watchdog: neither pulses timeout.
        if (tail_rel || !cur_req || (!fwd && cnt_q == TO_LAST)) begin
          state_d = IDLE;
          grant_d = '0;
          sel_d   = SEL_NONE;
          ptr_d   = sel;
          to_d    = !tail_rel && cur_req;
        end else if (fwd) begin
          cnt_d = '0;
        end else if (cnt_q != CNT_SAT) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      grant   <= '0;
      sel     <= SEL_NONE;
      ptr_q   <= 3'(P_S);
      cnt_q   <= '0;
      timeout <= 1'b0;
    end else begin
      state_q <= state_d;
      grant   <= grant_d;
      sel     <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      timeout <= to_d;
    end
  end

`ifdef ALLOC_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pkt_cnt <= '0;
      to_cnt  <= '0;
    end else begin
      if (tail_rel)                 pkt_cnt <= pkt_cnt + 16'd1;
      if (to_d && to_cnt != 8'hff)  to_cnt  <= to_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_out_port_alloc.sv
// tb_out_port_alloc -- randomized and directed bench for out_port_alloc with
// a packet-level reference model (owner index, last winner, stall count).
module tb_out_port_alloc;

  localparam logic [2:0] C_HEAD = 3'b001;
  localparam logic [2:0] C_BODY = 3'b010;
  localparam logic [2:0] C_TAIL = 3'b100;
  localparam int         TOM    = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  req = '0;
  logic [4:0]  flit_valid = '0;
  logic [14:0] flit_id = '0;
  logic        out_ready = 1'b0;
  logic [4:0]  grant;
  logic [2:0]  sel;
  logic        fwd, busy, timeout;
`ifdef ALLOC_STATS_EN
  logic [15:0] pkt_cnt;
  logic [7:0]  to_cnt;
`endif

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // reference model state
  int m_owner = -1;
  int m_ptr   = 4;
  int m_wd    = 0;
  bit m_to    = 0;
  int m_pkts  = 0;
  int m_tos   = 0;
  int m_fwd_port = -1;

  out_port_alloc #(.TO_W(12), .TO_MAX(12'd4)) dut (
    .clk(clk), .rst(rst), .req(req), .flit_valid(flit_valid),
    .flit_id(flit_id), .out_ready(out_ready), .grant(grant), .sel(sel),
    .fwd(fwd), .busy(busy), .timeout(timeout)
`ifdef ALLOC_STATS_EN
    , .pkt_cnt(pkt_cnt), .to_cnt(to_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] fid_of(input int j);
    fid_of = flit_id[3*j +: 3];
  endfunction

  task automatic model_reset();
    m_owner = -1; m_ptr = 4; m_wd = 0; m_to = 0; m_pkts = 0; m_tos = 0;
  endtask

  task automatic model_release(input bit to_pulse);
    m_ptr = m_owner;
    m_owner = -1;
    m_to = to_pulse;
  endtask

  task automatic model_step(input bit f);
    int j;
    m_fwd_port = f ? m_owner : -1;
    if (m_owner < 0) begin
      m_to = 0;
      for (int k = 1; k <= 5; k++) begin
        j = (m_ptr + k) % 5;
        if (m_owner < 0 && req[j] && flit_valid[j] && fid_of(j) == C_HEAD) begin
          m_owner = j;
          m_wd = 0;
        end
      end
    end else if (f && fid_of(m_owner) == C_TAIL) begin
      model_release(0);
      m_pkts = (m_pkts + 1) % 65536;
    end else if (!req[m_owner]) begin
      model_release(0);
    end else if (!f && m_wd == TOM - 1) begin
      model_release(1);
      if (m_tos < 255) m_tos++;
    end else begin
      m_to = 0;
      m_wd = f ? 0 : ((m_wd < 4095) ? m_wd + 1 : m_wd);
    end
  endtask

  // One clock: check fwd before the edge, step the model at the edge,
  // check registered outputs just after it. Starts and ends at posedge+1.
  task automatic cycle();
    bit         ef;
    logic [4:0] eg;
    logic [2:0] es;
    #3;
    ef = (m_owner >= 0) && flit_valid[m_owner] && out_ready;
    chk_cnt++;
    if (fwd !== ef) $display("FAIL fwd @%0t: got %b want %b", $time, fwd, ef);
    else pass_cnt++;
    @(posedge clk);
    model_step(ef);
    #1;
    eg = (m_owner < 0) ? 5'b0 : 5'(1 << m_owner);
    es = (m_owner < 0) ? 3'b111 : 3'(m_owner);
    chk_cnt++;
    if (grant !== eg) $display("FAIL grant @%0t: got %b want %b", $time, grant, eg);
    else pass_cnt++;
    chk_cnt++;
    if (sel !== es) $display("FAIL sel @%0t: got %0d want %0d", $time, sel, es);
    else pass_cnt++;
    chk_cnt++;
    if (busy !== (m_owner >= 0)) $display("FAIL busy @%0t: got %b want %b", $time, busy, m_owner >= 0);
    else pass_cnt++;
    chk_cnt++;
    if (timeout !== m_to) $display("FAIL timeout @%0t: got %b want %b", $time, timeout, m_to);
    else pass_cnt++;
`ifdef ALLOC_STATS_EN
    chk_cnt++;
    if (pkt_cnt !== 16'(m_pkts) || to_cnt !== 8'(m_tos))
      $display("FAIL stats @%0t: got %0d/%0d want %0d/%0d", $time, pkt_cnt, to_cnt, m_pkts, m_tos);
    else pass_cnt++;
`endif
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req = '0; flit_valid = '0; flit_id = '0; out_ready = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #2;
    chk_cnt++;
    if (grant !== 5'b0 || sel !== 3'b111 || busy !== 1'b0 || timeout !== 1'b0 || fwd !== 1'b0)
      $display("FAIL reset: got g=%b s=%0d b=%b t=%b f=%b want 0/7/0/0/0", grant, sel, busy, timeout, fwd);
    else pass_cnt++;
`ifdef ALLOC_STATS_EN
    chk_cnt++;
    if (pkt_cnt !== 16'd0 || to_cnt !== 8'd0)
      $display("FAIL reset_stats: got %0d/%0d want 0/0", pkt_cnt, to_cnt);
    else pass_cnt++;
`endif
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    req = 5'b00001; flit_valid = 5'b00001; flit_id[2:0] = C_HEAD; out_ready = 1'b1;
    cycle();
    chk_cnt++;
    if (grant !== 5'b00001 || sel !== 3'd0)
      $display("FAIL single_grant: got %b/%0d want 00001/0", grant, sel);
    else pass_cnt++;
    flit_id[2:0] = C_BODY; cycle();
    flit_id[2:0] = C_TAIL; cycle();
    chk_cnt++;
    if (grant !== 5'b0 || sel !== 3'b111)
      $display("FAIL single_release: got %b/%0d want 00000/7", grant, sel);
    else pass_cnt++;
  endtask

  task automatic test_round_robin();
    int   ph[5];
    int   order[$];
    int   exp_order[6] = '{0, 1, 2, 3, 4, 0};
    logic [2:0] prev;
    do_reset();
    foreach (ph[i]) ph[i] = 0;
    req = 5'h1f; flit_valid = 5'h1f; out_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && order.size() < 6; cyc++) begin
      for (int i = 0; i < 5; i++) flit_id[3*i +: 3] = (ph[i] == 0) ? C_HEAD : C_TAIL;
      prev = sel;
      cycle();
      if (m_fwd_port >= 0) ph[m_fwd_port] ^= 1;
      if (prev == 3'b111 && sel != 3'b111) order.push_back(int'(sel));
    end
    chk_cnt++;
    if (order.size() != 6) $display("FAIL rr_count: got %0d grants want 6", order.size());
    else pass_cnt++;
    for (int i = 0; i < 6 && i < order.size(); i++) begin
      chk_cnt++;
      if (order[i] != exp_order[i]) $display("FAIL rr_order[%0d]: got %0d want %0d", i, order[i], exp_order[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    req = 5'b00100; flit_valid = 5'b00100; flit_id = {5{C_HEAD}}; out_ready = 1'b0;
    cycle();
    n = 0;
    while (busy && n < 10) begin
      cycle();
      n++;
    end
    chk_cnt++;
    if (n != 4 || timeout !== 1'b1)
      $display("FAIL wd_release: got %0d cycles to=%b want 4 cycles to=1", n, timeout);
    else pass_cnt++;
    req = 5'b01010; flit_valid = 5'b01010;
    cycle();
    chk_cnt++;
    if (sel !== 3'd3) $display("FAIL wd_next: got %0d want 3", sel);
    else pass_cnt++;
  endtask

  task automatic test_abort();
    do_reset();
    req = 5'b00010; flit_valid = 5'b00010; flit_id = {5{C_HEAD}}; out_ready = 1'b1;
    cycle();
    flit_id[5:3] = C_BODY; cycle();
    req = 5'b0; cycle();
    chk_cnt++;
    if (grant !== 5'b0 || timeout !== 1'b0)
      $display("FAIL abort: got g=%b t=%b want 00000/0", grant, timeout);
    else pass_cnt++;
    req = 5'b00101; flit_valid = 5'b00101; flit_id = {5{C_HEAD}};
    cycle();
    chk_cnt++;
    if (sel !== 3'd2) $display("FAIL abort_next: got %0d want 2", sel);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 5'b10000; flit_valid = 5'b10000; flit_id = {5{C_HEAD}}; out_ready = 1'b1;
    cycle();
    flit_id[14:12] = C_BODY; cycle();
    #2 rst = 1'b0;
    #1;
    chk_cnt++;
    if (grant !== 5'b0 || sel !== 3'b111 || timeout !== 1'b0)
      $display("FAIL reset_mid: got g=%b s=%0d t=%b want 00000/7/0", grant, sel, timeout);
    else pass_cnt++;
    do_reset();
    req = 5'b10001; flit_valid = 5'b10001; flit_id = {5{C_HEAD}};
    cycle();
    chk_cnt++;
    if (sel !== 3'd0) $display("FAIL reset_mid_next: got %0d want 0", sel);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [2:0] codes[5] = '{C_HEAD, C_BODY, C_TAIL, 3'b000, 3'b111};
    do_reset();
    repeat (400) begin
      for (int i = 0; i < 5; i++) begin
        req[i]        = ($urandom_range(7) != 0);
        flit_valid[i] = ($urandom_range(3) != 0);
        flit_id[3*i +: 3] = codes[$urandom_range(4)];
      end
      out_ready = $urandom_range(1);
      cycle();
    end
  endtask

`ifdef ALLOC_STATS_EN
  task automatic test_stats();
    do_reset();
    out_ready = 1'b1; req = 5'b00001; flit_valid = 5'b00001;
    repeat (3) begin
      flit_id[2:0] = C_HEAD; cycle(); cycle();
      flit_id[2:0] = C_TAIL; cycle();
    end
    req = 5'b00100; flit_valid = 5'b00100; flit_id = {5{C_HEAD}}; out_ready = 1'b0;
    repeat (6) cycle();
    chk_cnt++;
    if (pkt_cnt !== 16'd3 || to_cnt !== 8'd1)
      $display("FAIL stats_total: got %0d/%0d want 3/1", pkt_cnt, to_cnt);
    else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_abort();
    test_reset_mid();
    test_random();
`ifdef ALLOC_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
